mul_div_unit: RTL
=================

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand and result width in bits.
REQ-002 The block SHALL have parameter MUL_LAT, default 5, giving multiply busy cycles (legal values 1..15).
REQ-003 The block SHALL have parameter DIV_LAT, default 10, giving divide busy cycles (legal values 1..15).
REQ-004 The block SHALL have one clock; reset is asynchronous and active-high.
REQ-005 clk  input  1  clock; all state changes on the rising edge.
REQ-006 reset  input  1  asynchronous, active-high reset.
REQ-007 start  input  1  request strobe; the operation is sampled on the rising edge.
REQ-008 op  input  3  operation: 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu.
REQ-009 a  input  WIDTH  first operand (multiplicand or dividend; mthi/mtlo source).
REQ-010 b  input  WIDTH  second operand (multiplier or divisor).
REQ-011 busy  output  1  high while a multiply or divide is in flight.
REQ-012 hi  output  WIDTH  HI register (upper product or remainder).
REQ-013 lo  output  WIDTH  LO register (lower product or quotient).

Function
REQ-014 The block SHALL accept start only when busy=0; start while busy=1 SHALL be ignored, with no effect on state.
REQ-015 An accepted mult, multu, div or divu SHALL latch a, b and op, load a counter with MUL_LAT or DIV_LAT, and set busy=1 from the next cycle.
REQ-016 busy SHALL stay high for exactly LAT cycles; on the edge ending the last cycle, hi/lo SHALL update and busy SHALL fall together.
REQ-017 hi and lo SHALL hold their previous values for the whole busy period, and SHALL change only on completion or on mthi/mtlo.
REQ-018 mult/multu SHALL form the 2*WIDTH-bit signed/unsigned product, with {hi,lo} = product.
REQ-019 div/divu SHALL give lo = quotient and hi = remainder; signed division truncates toward zero, and the remainder takes the dividend's sign.
REQ-020 Divide by zero SHALL give hi = a and lo = all ones, after the full DIV_LAT busy period.
REQ-021 Signed overflow (a = most-negative, b = -1) SHALL give lo = a and hi = 0.
REQ-022 mthi/mtlo SHALL write a into hi/lo on the accepting edge, with no busy assertion and the other register unchanged.
REQ-023 A start accepted on the same edge that busy falls SHALL be ignored, because busy was high when sampled; the earliest new accept is the following edge.
REQ-024 Operand changes after the accept SHALL NOT affect the in-flight result.

Reset
REQ-025 Asserting reset SHALL immediately force hi=0, lo=0 and busy=0, and SHALL clear the counter and latched operands.
REQ-026 Reset during a busy operation SHALL abort it, with no later completion write.
REQ-027 The first accept SHALL be possible on the first rising edge after reset deasserts.

Configuration
REQ-028 Macro MDU_MADD_EN SHALL control the accumulate operations.
REQ-029 With MDU_MADD_EN defined, op 6 (madd) and op 7 (maddu) SHALL behave as signed/unsigned multiply with MUL_LAT busy cycles, giving {hi,lo} = {hi,lo} + product modulo 2^(2*WIDTH).
REQ-030 The {hi,lo} addend for madd/maddu SHALL be the value present at completion.
REQ-031 With MDU_MADD_EN undefined, op 6 and op 7 SHALL be no-ops: no busy assertion and no change to hi/lo.

Verification
REQ-032 mult with a=0xFFFFFFFE (-2), b=3, defaults -> busy high 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-033 divu with a=100, b=7 -> busy high 10 cycles, then lo=14, hi=2; div with a=-7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-034 div with a=0x80000000, b=0 -> lo=0xFFFFFFFF, hi=0x80000000; div with a=0x80000000, b=-1 -> lo=0x80000000, hi=0.
REQ-035 mthi with a=0x12345678, then a mult start during busy (ignored), then a mult start on the busy-fall edge (ignored) -> accept only on the next edge, and hi=0x12345678 until then.
REQ-036 Reset asserted in cycle 3 of a div -> hi=lo=0 and busy=0 immediately, with no later write.
REQ-037 With MDU_MADD_EN defined: mtlo 5, then madd with a=2, b=3 -> lo=11, hi=0; with MDU_MADD_EN undefined, op 6 leaves lo=5 and busy=0.

Source files
------------

// File: rtl/mul_div_unit.sv
// mul_div_unit: multi-cycle multiply/divide unit with HI/LO result registers.
//
// Ports:
//   clk    - clock, all state changes on the rising edge
//   reset  - asynchronous active-high reset
//   start  - request strobe, sampled on the rising edge, accepted only when not busy
//   op     - 0 mult, 1 multu, 2 div, 3 divu, 4 mthi, 5 mtlo, 6 madd, 7 maddu
//   a, b   - operands (multiplicand/dividend, multiplier/divisor; a is the mthi/mtlo source)
//   busy   - high while a multiply or divide is in flight
//   hi, lo - HI/LO registers (upper product / remainder, lower product / quotient)
//
// Configuration macro: MDU_MADD_EN enables madd/maddu ({hi,lo} += product).
// Without it, op 6 and op 7 are accepted as no-ops.
//
// MUL_LAT and DIV_LAT must lie in 1..15 (4-bit busy counter).

module mul_div_unit #(
   parameter int unsigned WIDTH   = 32,
   parameter int unsigned MUL_LAT = 5,
   parameter int unsigned DIV_LAT = 10
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic [2:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic             busy,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam logic [2:0] OpMult  = 3'd0;
   localparam logic [2:0] OpMultu = 3'd1;
   localparam logic [2:0] OpDiv   = 3'd2;
   localparam logic [2:0] OpDivu  = 3'd3;
   localparam logic [2:0] OpMthi  = 3'd4;
   localparam logic [2:0] OpMtlo  = 3'd5;
   localparam logic [2:0] OpMadd  = 3'd6;
   localparam logic [2:0] OpMaddu = 3'd7;

   localparam logic [3:0] MulCnt = 4'(MUL_LAT);
   localparam logic [3:0] DivCnt = 4'(DIV_LAT);

   localparam logic [WIDTH-1:0] MostNeg = {1'b1, {(WIDTH-1){1'b0}}};
   localparam logic [WIDTH-1:0] OneVal  = {{(WIDTH-1){1'b0}}, 1'b1};

   // State
   logic             busy_q, busy_d;
   logic [3:0]       cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic [WIDTH-1:0] a_q, a_d;
   logic [WIDTH-1:0] b_q, b_d;
   logic [WIDTH-1:0] hi_q, hi_d;
   logic [WIDTH-1:0] lo_q, lo_d;

   // Datapath (operates only on latched operands)
   logic               signed_op;
   logic [2*WIDTH-1:0] mul_a_ext;
   logic [2*WIDTH-1:0] mul_b_ext;
   logic [2*WIDTH-1:0] prod;
   logic               a_neg;
   logic               b_neg;
   logic [WIDTH-1:0]   a_mag;
   logic [WIDTH-1:0]   b_mag;
   logic [WIDTH-1:0]   div_den;
   logic [WIDTH-1:0]   q_mag;
   logic [WIDTH-1:0]   r_mag;
   logic [WIDTH-1:0]   quot;
   logic [WIDTH-1:0]   rem;
   logic               div_zero;
   logic               div_ovf;
   logic [WIDTH-1:0]   res_hi;
   logic [WIDTH-1:0]   res_lo;

   always_comb begin
      // Signed variants (mult, div, madd) all have an even opcode.
      signed_op = ~op_q[0];

      mul_a_ext = signed_op ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
      mul_b_ext = signed_op ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
      // Low 2*WIDTH bits of the extended product equal the signed/unsigned product.
      prod      = mul_a_ext * mul_b_ext;

      // Signed divide via magnitudes: quotient truncates toward zero, remainder
      // follows the dividend sign.
      a_neg    = signed_op & a_q[WIDTH-1];
      b_neg    = signed_op & b_q[WIDTH-1];
      a_mag    = a_neg ? (~a_q + OneVal) : a_q;
      b_mag    = b_neg ? (~b_q + OneVal) : b_q;
      div_zero = (b_q == '0);
      div_ovf  = signed_op & (a_q == MostNeg) & (b_q == '1);
      // Keep the divider defined when the divisor is zero; the result is overridden.
      div_den  = div_zero ? OneVal : b_mag;
      q_mag    = a_mag / div_den;
      r_mag    = a_mag % div_den;
      quot     = (a_neg ^ b_neg) ? (~q_mag + OneVal) : q_mag;
      rem      = a_neg ? (~r_mag + OneVal) : r_mag;

      res_hi = hi_q;
      res_lo = lo_q;
      case (op_q)
         OpMult, OpMultu: begin
            res_hi = prod[2*WIDTH-1:WIDTH];
            res_lo = prod[WIDTH-1:0];
         end
         OpDiv, OpDivu: begin
            if (div_zero) begin
               res_hi = a_q;
               res_lo = '1;
            end else if (div_ovf) begin
               res_hi = '0;
               res_lo = a_q;
            end else begin
               res_hi = rem;
               res_lo = quot;
            end
         end
`ifdef MDU_MADD_EN
         OpMadd, OpMaddu: begin
            // Addend is the current {hi,lo}, which cannot change while busy.
            {res_hi, res_lo} = {hi_q, lo_q} + prod;
         end
`endif
         default: begin
            res_hi = hi_q;
            res_lo = lo_q;
         end
      endcase
   end

   // Next-state logic
   always_comb begin
      busy_d = busy_q;
      cnt_d  = cnt_q;
      op_d   = op_q;
      a_d    = a_q;
      b_d    = b_q;
      hi_d   = hi_q;
      lo_d   = lo_q;

      if (busy_q) begin
         // start is ignored for the whole busy period, including the final edge.
         cnt_d = cnt_q - 4'd1;
         if (cnt_q == 4'd1) begin
            busy_d = 1'b0;
            hi_d   = res_hi;
            lo_d   = res_lo;
         end
      end else if (start) begin
         case (op)
            OpMult, OpMultu: begin
               busy_d = 1'b1;
               cnt_d  = MulCnt;
               op_d   = op;
               a_d    = a;
               b_d    = b;
            end
            OpDiv, OpDivu: begin
               busy_d = 1'b1;
               cnt_d  = DivCnt;
               op_d   = op;
               a_d    = a;
               b_d    = b;
            end
            OpMthi: hi_d = a;
            OpMtlo: lo_d = a;
`ifdef MDU_MADD_EN
            OpMadd, OpMaddu: begin
               busy_d = 1'b1;
               cnt_d  = MulCnt;
               op_d   = op;
               a_d    = a;
               b_d    = b;
            end
`else
            OpMadd, OpMaddu: begin
               busy_d = busy_q;
            end
`endif
            default: begin
               busy_d = busy_q;
            end
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         busy_q <= 1'b0;
         cnt_q  <= '0;
         op_q   <= '0;
         a_q    <= '0;
         b_q    <= '0;
         hi_q   <= '0;
         lo_q   <= '0;
      end else begin
         busy_q <= busy_d;
         cnt_q  <= cnt_d;
         op_q   <= op_d;
         a_q    <= a_d;
         b_q    <= b_d;
         hi_q   <= hi_d;
         lo_q   <= lo_d;
      end
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule
